// File: rtl/muladd_pkg.sv
// Shared widths and serializer state for the multiply-add result path.
// The 8-word packer takes its widths from here as well.
package muladd_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int BLK_W     = WORD_W * NUM_WORDS;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/unshift_buffer_if.sv
// Block-in / word-out stream bundle for unshift_buffer.
// Signal names are seen from the serializer's side.
interface unshift_buffer_if #(
    parameter int WORD_W    = muladd_pkg::WORD_W,
    parameter int NUM_WORDS = muladd_pkg::NUM_WORDS
);

    logic [WORD_W*NUM_WORDS-1:0] data_i;
    logic                        data_valid_i;
    logic                        data_ready_o;
    logic [WORD_W-1:0]           data_o;
    logic                        wr_en_o;
    logic                        ready_i;
    logic                        last_o;

    modport slave (
        input  data_i, data_valid_i, ready_i,
        output data_ready_o, data_o, wr_en_o, last_o
    );

    modport master (
        output data_i, data_valid_i, ready_i,
        input  data_ready_o, data_o, wr_en_o, last_o
    );

endinterface

// File: rtl/unshift_buffer.sv
// Block-to-word serializer: one wide block in, NUM_WORDS words out, MS word first,
// with a one-block staging register so consecutive blocks stream without a bubble.
module unshift_buffer
    import muladd_pkg::*;
#(
    parameter int WORD_W    = muladd_pkg::WORD_W,
    parameter int NUM_WORDS = muladd_pkg::NUM_WORDS
) (
    input logic             clk_data,
    input logic             rst_n,
    unshift_buffer_if.slave bus
);

    localparam int BLK_W_L = WORD_W * NUM_WORDS;
    localparam int CNT_W   = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);

    ser_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BLK_W_L-1:0] sr_q,    sr_d;
    logic [BLK_W_L-1:0] pend_q,  pend_d;
    logic               pend_v_q, pend_v_d;
    logic               rdy_q,   rdy_d;

    logic               accept;
    logic               xfer;
    logic [BLK_W_L-1:0] sr_shifted;

    assign accept     = bus.data_valid_i && rdy_q;
    assign xfer       = (state_q == SEND) && bus.ready_i;
    assign sr_shifted = {sr_q[BLK_W_L-WORD_W-1:0], {WORD_W{1'b0}}};

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves
        // one unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = bus.data_i;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end

            SEND: begin
                if (xfer && cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (pend_v_q) begin
                        sr_d     = pend_q;
                        pend_v_d = 1'b0;
                    end else if (accept) begin
                        sr_d = bus.data_i;
                    end else begin
                        sr_d    = sr_shifted;
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        sr_d  = sr_shifted;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // Any accept not taken by the final-word reload is staged.
                    if (accept) begin
                        pend_d   = bus.data_i;
                        pend_v_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Ready is the registered image of "staging slot will be free".
        rdy_d = !pend_v_d;
    end

    always_ff @(posedge clk_data) begin
        if (!rst_n) begin
            // NOTE: the wide sr/pend registers are cleared too, so data_o reads 0 out of
            // reset and a dropped block leaves no residue behind.
            state_q  <= IDLE;
            cnt_q    <= '0;
            sr_q     <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the pre-edge
            // values, independent of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.data_o       = sr_q[BLK_W_L-1 -: WORD_W];
    assign bus.wr_en_o      = (state_q == SEND);
    assign bus.last_o       = (cnt_q == CNT_LAST);
    assign bus.data_ready_o = rdy_q;

endmodule

// File: tb/tb_unshift_buffer.sv
// Directed bench for unshift_buffer: reset, single block, streaming, backpressure,
// final-word reload, mid-block reset and a packer loopback with random blocks.
module tb_unshift_buffer;

    logic clk_data = 1'b0;
    logic rst_n;

    unshift_buffer_if bus ();

    unshift_buffer dut (
        .clk_data (clk_data),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    always #5 clk_data = ~clk_data;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_data);
        #1;
    endtask

    function automatic logic [255:0] mk_blk(input logic [31:0] base, input logic [31:0] step);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[255-32*k -: 32] = base + step * 32'(k);
        return b;
    endfunction

    function automatic logic [255:0] rand_blk();
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[32*k +: 32] = $urandom();
        return b;
    endfunction

    task automatic check_word(input string tag, input logic [31:0] w, input logic lst);
        check({tag, "_data"}, 256'(bus.data_o), 256'(w));
        check({tag, "_wr_en"}, 256'(bus.wr_en_o), 256'(1'b1));
        check({tag, "_last"}, 256'(bus.last_o), 256'(lst));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    logic [255:0] sent_q[$];
    logic [255:0] cur, pk;
    logic         acc, xf;
    logic [31:0]  w;
    int           n_offer, n_got, nw;

    initial begin
        rst_n            = 1'b0;
        bus.data_i       = '0;
        bus.data_valid_i = 1'b0;
        bus.ready_i      = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_wr_en", 256'(bus.wr_en_o), 256'(1'b0));
        check("rst_data",  256'(bus.data_o), 256'(0));
        check("rst_last",  256'(bus.last_o), 256'(1'b0));
        check("rst_ready", 256'(bus.data_ready_o), 256'(1'b0));

        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 256'(bus.data_ready_o), 256'(1'b1));

        // Single block 7..0, word 0 (=7) first
        bus.data_i = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        bus.data_valid_i = 1'b1;
        tick();
        bus.data_valid_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_word($sformatf("single_w%0d", k), 32'(7 - k), k == 7);
            tick();
        end
        check("single_idle_wr_en", 256'(bus.wr_en_o), 256'(1'b0));
        check("single_idle_data",  256'(bus.data_o), 256'(0));

        // Back-to-back A then B: B staged while A streams
        bus.data_i = mk_blk(32'hA5A5_0000, 32'd1);
        bus.data_valid_i = 1'b1;
        tick();
        bus.data_i = mk_blk(32'hB000_0000, 32'd1);
        for (int i = 0; i < 16; i++) begin
            check_word($sformatf("b2b_%0d", i),
                       (i < 8) ? 32'hA5A5_0000 + 32'(i) : 32'hB000_0000 + 32'(i - 8), (i % 8) == 7);
            check($sformatf("b2b_ready_%0d", i), 256'(bus.data_ready_o),
                  256'((i >= 1 && i <= 7) ? 1'b0 : 1'b1));
            tick();
            if (i == 0) bus.data_valid_i = 1'b0;
        end
        check("b2b_idle_wr_en", 256'(bus.wr_en_o), 256'(1'b0));

        // Backpressure: stall 5 cycles on word 2
        bus.data_i = mk_blk(32'hC000_0000, 32'h11);
        bus.data_valid_i = 1'b1;
        tick();
        bus.data_valid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_word($sformatf("bp_w%0d", k), 32'hC000_0000 + 32'h11 * 32'(k), 1'b0);
            tick();
        end
        check_word("bp_w2", 32'hC000_0022, 1'b0);
        bus.ready_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            check_word($sformatf("bp_stall%0d", s), 32'hC000_0022, 1'b0);
        end
        bus.ready_i = 1'b1;
        tick();
        for (int k = 3; k < 8; k++) begin
            check_word($sformatf("bp_w%0d", k), 32'hC000_0000 + 32'h11 * 32'(k), k == 7);
            tick();
        end
        check("bp_idle_wr_en", 256'(bus.wr_en_o), 256'(1'b0));

        // Final-word direct load: E offered exactly on D's word-7 transfer
        bus.data_i = mk_blk(32'hD00D_0000, 32'd1);
        bus.data_valid_i = 1'b1;
        tick();
        bus.data_valid_i = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check_word("fw_d7", 32'hD00D_0007, 1'b1);
        bus.data_i = mk_blk(32'hEEEE_0000, 32'd1);
        bus.data_valid_i = 1'b1;
        tick();
        bus.data_valid_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_word($sformatf("fw_e%0d", k), 32'hEEEE_0000 + 32'(k), k == 7);
            check($sformatf("fw_ready_%0d", k), 256'(bus.data_ready_o), 256'(1'b1));
            tick();
        end
        check("fw_idle_wr_en", 256'(bus.wr_en_o), 256'(1'b0));

        // Reset on word 4 with G pending
        bus.data_i = mk_blk(32'hF000_0000, 32'd1);
        bus.data_valid_i = 1'b1;
        tick();
        bus.data_i = mk_blk(32'h6000_0000, 32'd1);
        tick();
        bus.data_valid_i = 1'b0;
        repeat (3) tick();
        check_word("mr_f4", 32'hF000_0004, 1'b0);
        check("mr_ready_pend", 256'(bus.data_ready_o), 256'(1'b0));
        rst_n = 1'b0;
        tick();
        check("mr_rst_wr_en", 256'(bus.wr_en_o), 256'(1'b0));
        check("mr_rst_data",  256'(bus.data_o), 256'(0));
        check("mr_rst_last",  256'(bus.last_o), 256'(1'b0));
        check("mr_rst_ready", 256'(bus.data_ready_o), 256'(1'b0));
        rst_n = 1'b1;
        tick();
        check("mr_ready_after", 256'(bus.data_ready_o), 256'(1'b1));
        for (int s = 0; s < 10; s++) begin
            check($sformatf("mr_quiet_%0d", s), 256'(bus.wr_en_o), 256'(1'b0));
            tick();
        end

        // Loopback through a packer model with random blocks and random backpressure
        n_offer = 0; n_got = 0; nw = 0; pk = '0;
        cur = rand_blk();
        bus.data_i = cur;
        for (int cyc = 0; cyc < 2000 && n_got < 4; cyc++) begin
            bus.data_valid_i = (n_offer < 4) && ($urandom_range(0, 3) != 0);
            bus.ready_i      = ($urandom_range(0, 3) != 0);
            acc = bus.data_valid_i && bus.data_ready_o;
            xf  = bus.wr_en_o && bus.ready_i;
            w   = bus.data_o;
            tick();
            if (acc) begin
                sent_q.push_back(cur);
                n_offer++;
                cur = rand_blk();
                bus.data_i = cur;
            end
            if (xf) begin
                pk = {pk[223:0], w};
                nw++;
                if (nw == 8) begin
                    nw = 0;
                    n_got++;
                    if (sent_q.size() > 0) check($sformatf("loop_blk%0d", n_got), pk, sent_q.pop_front());
                    else check("loop_unexpected_blk", 256'(n_got), 256'(0));
                end
            end
        end
        bus.data_valid_i = 1'b0;
        bus.ready_i      = 1'b1;
        check("loop_blocks_received", 256'(n_got), 256'(4));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
